// File: rtl/clock_cfg_sequencer.sv
// clock_cfg_sequencer
// Sequences clock-mode changes from the core's CLK register toward altera_clock.
// Every change goes through a drain window with the cogs stalled, then the new mode is
// applied, then the bench of PLL/oscillator settle time elapses before the stall is released.
// A rising edge on cfg_in[7] is turned into a one-clock soft-reset request.
//
// Optional feature macro: CLKSEQ_FASTPATH_EN
//   When defined, a change that only touches CLKSEL [2:0] (PLLENA/OSCENA/OSCM [6:3]
//   unchanged) skips the settle window because no oscillator or PLL is restarted.
//   When undefined, every change runs the full drain/apply/settle sequence.

module clock_cfg_sequencer #(
  parameter logic [6:0] RESET_CFG     = 7'h00,
  parameter int         HOLD_CYCLES   = 16,
  parameter int         SETTLE_CYCLES = 1_600_000,
  parameter int         CNT_W         = 21
) (
  input  logic       clock,
  input  logic       res,
  input  logic [7:0] cfg_in,
  output logic [6:0] cfg_out,
  output logic       hold,
  output logic       busy,
  output logic       soft_res,
  output logic [7:0] changes
);

  // Largest value the down-counter can be loaded with.
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  // Refuse to build when a window length cannot be represented by the counter.
  generate
    if (HOLD_CYCLES < 1 || longint'(HOLD_CYCLES) > CNT_MAX) begin : g_bad_hold
      $error("clock_cfg_sequencer: HOLD_CYCLES out of range for CNT_W");
    end
    if (SETTLE_CYCLES < 1 || longint'(SETTLE_CYCLES) > CNT_MAX) begin : g_bad_settle
      $error("clock_cfg_sequencer: SETTLE_CYCLES out of range for CNT_W");
    end
  endgenerate

  // Counter load values; the counter runs from LOAD down to 0 inclusive.
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    APPLY  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [6:0]       pend;
  logic             cfg7_q;
  logic             cfg_differs;

`ifdef CLKSEQ_FASTPATH_EN
  logic             fast_pend;
  logic             fast_eligible;
`endif

  // Saturating increment for the completed-change counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A new sequence is wanted whenever the requested mode differs from the applied one.
  assign cfg_differs = (cfg_in[6:0] != cfg_out);

`ifdef CLKSEQ_FASTPATH_EN
  // Only a CLKSEL change with oscillator/PLL controls untouched may skip settling.
  assign fast_eligible = (cfg_in[6:3] == cfg_out[6:3]);
`endif

  // Soft-reset edge detector; primed high on reset so a stuck bit does not fire on exit.
  always_ff @(posedge clock) begin
    if (res) begin
      cfg7_q   <= 1'b1;
      soft_res <= 1'b0;
    end else begin
      cfg7_q   <= cfg_in[7];
      soft_res <= cfg_in[7] & ~cfg7_q;
    end
  end

  // Main sequencer: stall, drain, apply the new mode, settle, release.
  always_ff @(posedge clock) begin
    if (res) begin
      state   <= IDLE;
      counter <= '0;
      pend    <= RESET_CFG;
      cfg_out <= RESET_CFG;
      hold    <= 1'b0;
      busy    <= 1'b0;
      changes <= 8'h00;
`ifdef CLKSEQ_FASTPATH_EN
      fast_pend <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cfg_differs) begin
            pend    <= cfg_in[6:0];
            counter <= HOLD_LOAD;
            hold    <= 1'b1;
            busy    <= 1'b1;
            state   <= DRAIN;
`ifdef CLKSEQ_FASTPATH_EN
            fast_pend <= fast_eligible;
`endif
          end
        end

        DRAIN: begin
          hold <= 1'b1;
          busy <= 1'b1;
          if (counter == '0) begin
            state <= APPLY;
          end else begin
            counter <= counter - 1'b1;
          end
        end

        APPLY: begin
          cfg_out <= pend;
`ifdef CLKSEQ_FASTPATH_EN
          if (fast_pend) begin
            hold    <= 1'b0;
            busy    <= 1'b0;
            changes <= sat_inc(changes);
            counter <= '0;
            state   <= IDLE;
          end else begin
            hold    <= 1'b1;
            busy    <= 1'b1;
            counter <= SETTLE_LOAD;
            state   <= SETTLE;
          end
`else
          hold    <= 1'b1;
          busy    <= 1'b1;
          counter <= SETTLE_LOAD;
          state   <= SETTLE;
`endif
        end

        SETTLE: begin
          if (counter == '0) begin
            hold    <= 1'b0;
            busy    <= 1'b0;
            changes <= sat_inc(changes);
            state   <= IDLE;
          end else begin
            hold    <= 1'b1;
            busy    <= 1'b1;
            counter <= counter - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          hold  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_cfg_sequencer.sv
// Testbench for clock_cfg_sequencer with short hold/settle windows.
// A behavioural model tracks each sequence as "cycles since start" and derives
// the expected mode, stall and change count from the window lengths alone.

module tb_clock_cfg_sequencer;

  localparam int         HOLD   = 4;
  localparam int         SETTLE = 20;
  localparam logic [6:0] RCFG   = 7'h00;
`ifdef CLKSEQ_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       res = 1'b1;
  logic [7:0] cfg_in = 8'h00;
  logic [6:0] cfg_out;
  logic       hold;
  logic       busy;
  logic       soft_res;
  logic [7:0] changes;

  int checkCount = 0;
  int passCount = 0;

  // Model state
  logic [6:0] mOut = RCFG;
  logic [6:0] mPend = RCFG;
  logic [7:0] mChanges = 8'h00;
  logic       mSoft = 1'b0;
  logic       mPrev7 = 1'b1;
  bit         mInSeq = 1'b0;
  int         mElapsed = 0;
  int         mLen = 0;

  // Observed hold-run length and soft-reset pulse tally
  int holdRun = 0;
  int lastHoldRun = 0;
  int softCount = 0;

  clock_cfg_sequencer #(
    .RESET_CFG    (RCFG),
    .HOLD_CYCLES  (HOLD),
    .SETTLE_CYCLES(SETTLE),
    .CNT_W        (21)
  ) dut (
    .clock   (clock),
    .res     (res),
    .cfg_in  (cfg_in),
    .cfg_out (cfg_out),
    .hold    (hold),
    .busy    (busy),
    .soft_res(soft_res),
    .changes (changes)
  );

  always #5 clock = ~clock;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Advance the reference model by one clock edge using the inputs seen at that edge.
  task automatic modelEdge(input logic [7:0] c, input logic r);
    if (r) begin
      mOut = RCFG; mInSeq = 0; mSoft = 0; mChanges = 0; mPrev7 = 1; mElapsed = 0;
    end else begin
      mSoft  = c[7] && !mPrev7;
      mPrev7 = c[7];
      if (!mInSeq) begin
        if (c[6:0] != mOut) begin
          mInSeq = 1; mElapsed = 0; mPend = c[6:0];
          mLen = (FAST && c[6:3] == mOut[6:3]) ? HOLD + 1 : HOLD + 1 + SETTLE;
        end
      end else begin
        mElapsed++;
        if (mElapsed == HOLD + 1) mOut = mPend;
        if (mElapsed == mLen) begin
          mInSeq = 0;
          if (mChanges != 8'hFF) mChanges = mChanges + 8'd1;
        end
      end
    end
  endtask

  // Drive one clock of stimulus, update the model, then compare on the falling edge.
  task automatic applyStimulus(input logic [7:0] c, input logic r);
    cfg_in = c;
    res = r;
    @(posedge clock);
    modelEdge(c, r);
    @(negedge clock);
    checkOutput("cfg_out", 32'(cfg_out), 32'(mOut));
    checkOutput("hold", 32'(hold), 32'(mInSeq));
    checkOutput("busy", 32'(busy), 32'(mInSeq));
    checkOutput("soft_res", 32'(soft_res), 32'(mSoft));
    checkOutput("changes", 32'(changes), 32'(mChanges));
    if (soft_res === 1'b1) softCount++;
    if (hold === 1'b1) holdRun++;
    else if (holdRun > 0) begin
      lastHoldRun = holdRun;
      holdRun = 0;
    end
  endtask

  task automatic runCycles(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) applyStimulus(c, 1'b0);
  endtask

  initial begin
    logic [7:0] rc;
    logic       rr;

    // 1: reset for three clocks, then release with no soft reset
    $display("[TB] reset");
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b1);
    softCount = 0;
    runCycles(8'h00, 3);
    checkOutput("reset_soft", 32'(softCount), 32'd0);

    // 2: single full change
    $display("[TB] single change");
    lastHoldRun = 0;
    runCycles(8'h6F, 30);
    checkOutput("single_hold_len", 32'(lastHoldRun), 32'(HOLD + 1 + SETTLE));
    checkOutput("single_changes", 32'(changes), 32'd1);

    // 3: write during settle is ignored, then re-sequenced
    $display("[TB] mid-sequence write");
    runCycles(8'h6A, 1);
    runCycles(8'h6F, 10);
    runCycles(8'h6A, 60);
    checkOutput("mid_cfg", 32'(cfg_out), 32'h6A);

    // 4: reset abort during drain
    $display("[TB] reset abort");
    for (int i = 0; i < 2; i++) applyStimulus(8'h00, 1'b1);
    runCycles(8'h68, 3);
    applyStimulus(8'h68, 1'b1);
    checkOutput("abort_hold", 32'(hold), 32'd0);
    checkOutput("abort_cfg", 32'(cfg_out), 32'h00);
    runCycles(8'h68, 30);
    checkOutput("abort_restart_cfg", 32'(cfg_out), 32'h68);

    // 5: soft reset during settle
    $display("[TB] soft reset");
    runCycles(8'h6F, 12);
    softCount = 0;
    runCycles(8'hEF, 30);
    checkOutput("soft_count", 32'(softCount), 32'd1);
    checkOutput("soft_cfg", 32'(cfg_out), 32'h6F);

    // 6: CLKSEL-only change
    $display("[TB] clksel-only change");
    lastHoldRun = 0;
    runCycles(8'h6A, 30);
    checkOutput("fast_hold_len", 32'(lastHoldRun), FAST ? 32'(HOLD + 1) : 32'(HOLD + 1 + SETTLE));

    // Randomized traffic
    $display("[TB] random");
    rc = cfg_in;
    for (int i = 0; i < 2500; i++) begin
      rr = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 14) == 0) begin
        case ($urandom_range(0, 2))
          0: rc = 8'($urandom);
          1: rc = {rc[7:3], 3'($urandom)};
          default: rc = rc ^ 8'h80;
        endcase
      end
      applyStimulus(rc, rr);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
